// File: rtl/md_pkg.sv
// Shared multiply/divide definitions: MD opcode values (also used by ID decode)
// and the iteration FSM state type.
package md_pkg;

    localparam logic [2:0] MD_MULT  = 3'd0;
    localparam logic [2:0] MD_MULTU = 3'd1;
    localparam logic [2:0] MD_DIV   = 3'd2;
    localparam logic [2:0] MD_DIVU  = 3'd3;
    localparam logic [2:0] MD_MTHI  = 3'd4;
    localparam logic [2:0] MD_MTLO  = 3'd5;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_FIX  = 2'd3
    } md_state_e;

endpackage

// File: rtl/md_iter_core.sv
// Iterative datapath: shift-add multiply / restoring divide on unsigned magnitudes.
// Control (load/step/mode) comes from the FSM in ex_muldiv.
module md_iter_core #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic             step_i,
    input  logic             div_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             last_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);

    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH:0]     add_sum;
    logic               rem_ge;
    logic [WIDTH-1:0]   rem_diff;

    // Shifted partial remainder needs WIDTH+1 bits; the difference always fits WIDTH.
    assign add_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, b_q};
    assign rem_ge   = acc_q[2*WIDTH-1:WIDTH-1] >= {1'b0, b_q};
    assign rem_diff = acc_q[2*WIDTH-2:WIDTH-1] - b_q;

    always_comb begin
        acc_d = acc_q;
        b_d   = b_q;
        cnt_d = cnt_q;
        if (load_i) begin
            acc_d = {{WIDTH{1'b0}}, a_i};
            b_d   = b_i;
            cnt_d = '0;
        end else if (step_i) begin
            cnt_d = cnt_q + CNT_W'(1);
            if (div_i) begin
                if (rem_ge) acc_d = {rem_diff, acc_q[WIDTH-2:0], 1'b1};
                else        acc_d = {acc_q[2*WIDTH-2:0], 1'b0};
            end else begin
                if (acc_q[0]) acc_d = {add_sum, acc_q[WIDTH-1:1]};
                else          acc_d = {1'b0, acc_q[2*WIDTH-1:1]};
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
            b_q   <= '0;
            cnt_q <= '0;
        end else begin
            acc_q <= acc_d;
            b_q   <= b_d;
            cnt_q <= cnt_d;
        end
    end

    assign last_o = (cnt_q == CNT_W'(WIDTH - 1));
    assign hi_o   = acc_q[2*WIDTH-1:WIDTH];
    assign lo_o   = acc_q[WIDTH-1:0];

endmodule

// File: rtl/ex_muldiv.sv
// EX-stage multiply/divide unit: operand sign handling, iteration FSM and the
// architectural HI/LO registers around md_iter_core.
module ex_muldiv
    import md_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             MdStartE,
    input  logic [2:0]       MdOpE,
    input  logic [WIDTH-1:0] SrcAE,
    input  logic [WIDTH-1:0] SrcBE,
    output logic             BusyE,
    output logic             DoneE,
    output logic             DivZeroE,
    output logic [WIDTH-1:0] HiE,
    output logic [WIDTH-1:0] LoE
);

    md_state_e        state_q, state_d;
    logic [WIDTH-1:0] hi_q, lo_q;
    logic             done_q, dz_q;
    logic             neg_hi_q, neg_lo_q, is_div_q, dz_pend_q;

    logic             idle_start, start_md, signed_op, div_op, b_zero;
    logic             a_neg, b_neg, last;
    logic [WIDTH-1:0] a_mag, b_mag, core_hi, core_lo, res_hi, res_lo;
    logic [2*WIDTH-1:0] prod;

    assign idle_start = MdStartE && (state_q == S_IDLE);
    assign start_md   = idle_start && (MdOpE <= MD_DIVU);
    assign signed_op  = (MdOpE == MD_MULT) || (MdOpE == MD_DIV);
    assign div_op     = (MdOpE == MD_DIV)  || (MdOpE == MD_DIVU);
    assign b_zero     = (SrcBE == '0);
    assign a_neg      = signed_op && SrcAE[WIDTH-1];
    assign b_neg      = signed_op && SrcBE[WIDTH-1];
    assign a_mag      = a_neg ? -SrcAE : SrcAE;
    assign b_mag      = b_neg ? -SrcBE : SrcBE;

    md_iter_core #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_core (
        .clk    (clk),
        .rst_n  (rst_n),
        .load_i (start_md),
        .step_i ((state_q == S_MUL) || (state_q == S_DIV)),
        .div_i  (state_q == S_DIV),
        .a_i    (a_mag),
        .b_i    (b_mag),
        .last_o (last),
        .hi_o   (core_hi),
        .lo_o   (core_lo)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: if (start_md) state_d = div_op ? (b_zero ? S_FIX : S_DIV) : S_MUL;
            S_MUL,
            S_DIV:  if (last) state_d = S_FIX;
            S_FIX:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // On divide-by-zero the core still holds |A|; re-negating it restores SrcAE.
    always_comb begin
        prod   = {core_hi, core_lo};
        res_hi = core_hi;
        res_lo = core_lo;
        if (dz_pend_q) begin
            res_lo = '1;
            res_hi = neg_hi_q ? -core_lo : core_lo;
        end else if (is_div_q) begin
            res_hi = neg_hi_q ? -core_hi : core_hi;
            res_lo = neg_lo_q ? -core_lo : core_lo;
        end else begin
            if (neg_lo_q) prod = -prod;
            res_hi = prod[2*WIDTH-1:WIDTH];
            res_lo = prod[WIDTH-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            hi_q      <= '0;
            lo_q      <= '0;
            done_q    <= 1'b0;
            dz_q      <= 1'b0;
            neg_hi_q  <= 1'b0;
            neg_lo_q  <= 1'b0;
            is_div_q  <= 1'b0;
            dz_pend_q <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= (state_q == S_FIX);
            dz_q    <= (state_q == S_FIX) && dz_pend_q;
            if (start_md) begin
                is_div_q  <= div_op;
                dz_pend_q <= div_op && b_zero;
                neg_lo_q  <= a_neg ^ b_neg;
                neg_hi_q  <= div_op ? a_neg : (a_neg ^ b_neg);
            end
            if (state_q == S_FIX) begin
                hi_q <= res_hi;
                lo_q <= res_lo;
            end else if (idle_start && (MdOpE == MD_MTHI)) begin
                hi_q <= SrcAE;
            end else if (idle_start && (MdOpE == MD_MTLO)) begin
                lo_q <= SrcAE;
            end
        end
    end

    assign BusyE    = (state_q != S_IDLE);
    assign DoneE    = done_q;
    assign DivZeroE = dz_q;
    assign HiE      = hi_q;
    assign LoE      = lo_q;

endmodule

// File: tb/tb_ex_muldiv.sv
// Directed bench for ex_muldiv: hand-computed HI/LO, busy length and pulse counts.
module tb_ex_muldiv;

    logic        clk;
    logic        rst_n;
    logic        MdStartE;
    logic [2:0]  MdOpE;
    logic [31:0] SrcAE;
    logic [31:0] SrcBE;
    logic        BusyE;
    logic        DoneE;
    logic        DivZeroE;
    logic [31:0] HiE;
    logic [31:0] LoE;

    int n_cmp = 0;
    int n_err = 0;
    int busy_n, done_n, dz_n;

    ex_muldiv #(
        .WIDTH (32),
        .CNT_W (6)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .MdStartE (MdStartE),
        .MdOpE    (MdOpE),
        .SrcAE    (SrcAE),
        .SrcBE    (SrcBE),
        .BusyE    (BusyE),
        .DoneE    (DoneE),
        .DivZeroE (DivZeroE),
        .HiE      (HiE),
        .LoE      (LoE)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive a start at a negedge; it is sampled at the following posedge.
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        MdStartE = 1'b1;
        MdOpE    = op;
        SrcAE    = a;
        SrcBE    = b;
    endtask

    // Observe n cycles (bounded), dropping the start after its edge.
    task automatic run(input int n);
        busy_n = 0;
        done_n = 0;
        dz_n   = 0;
        repeat (n) begin
            @(negedge clk);
            MdStartE = 1'b0;
            busy_n += int'(BusyE);
            done_n += int'(DoneE);
            dz_n   += int'(DivZeroE);
        end
    endtask

    task automatic op_check(input string tag, input logic [2:0] op,
                            input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                            input int exp_busy, input int exp_dz);
        issue(op, a, b);
        run(40);
        check({tag, " hi"},   HiE, exp_hi);
        check({tag, " lo"},   LoE, exp_lo);
        check({tag, " busy"}, 32'(busy_n), 32'(exp_busy));
        check({tag, " done"}, 32'(done_n), 32'd1);
        check({tag, " dz"},   32'(dz_n), 32'(exp_dz));
    endtask

    initial begin
        rst_n    = 1'b0;
        MdStartE = 1'b0;
        MdOpE    = 3'd0;
        SrcAE    = '0;
        SrcBE    = '0;
        repeat (2) @(negedge clk);
        check("rst busy", {31'd0, BusyE}, 32'd0);
        check("rst done", {31'd0, DoneE}, 32'd0);
        check("rst dz",   {31'd0, DivZeroE}, 32'd0);
        check("rst hi",   HiE, 32'd0);
        check("rst lo",   LoE, 32'd0);
        rst_n = 1'b1;

        op_check("multu max",  3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 33, 0);
        op_check("mult -3*7",  3'd0, 32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFFF, 32'hFFFF_FFEB, 33, 0);
        op_check("multu 2^32", 3'd1, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 32'h0000_0000, 33, 0);
        op_check("div -7/2",   3'd2, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 33, 0);
        op_check("divu 7/2",   3'd3, 32'd7,         32'd2,         32'd1,         32'd3,         33, 0);
        op_check("div ovf",    3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000, 33, 0);
        op_check("div 100/-7", 3'd2, 32'd100,       32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFF2, 33, 0);
        op_check("divu 5/0",   3'd3, 32'd5,         32'd0,         32'd5,         32'hFFFF_FFFF, 1,  1);
        op_check("div -5/0",   3'd2, 32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFB, 32'hFFFF_FFFF, 1,  1);

        // MTHI then MTLO on consecutive edges
        issue(3'd4, 32'h0000_1234, 32'd0);
        @(negedge clk);
        check("mthi hi",   HiE, 32'h0000_1234);
        check("mthi busy", {31'd0, BusyE}, 32'd0);
        MdOpE = 3'd5;
        SrcAE = 32'h0000_5678;
        @(negedge clk);
        MdStartE = 1'b0;
        check("mtlo lo",   LoE, 32'h0000_5678);
        check("mtlo hi",   HiE, 32'h0000_1234);
        check("mtlo busy", {31'd0, BusyE}, 32'd0);

        // Reserved opcode is a no-op
        issue(3'd6, 32'hAAAA_AAAA, 32'h5555_5555);
        run(4);
        check("rsvd hi",   HiE, 32'h0000_1234);
        check("rsvd lo",   LoE, 32'h0000_5678);
        check("rsvd busy", 32'(busy_n), 32'd0);
        check("rsvd done", 32'(done_n), 32'd0);

        // MTHI while a MULT iterates must be ignored
        issue(3'd0, 32'hFFFF_FFFD, 32'd7);
        run(3);
        check("mid busy", {31'd0, BusyE}, 32'd1);
        MdStartE = 1'b1;
        MdOpE    = 3'd4;
        SrcAE    = 32'hDEAD_BEEF;
        @(negedge clk);
        MdStartE = 1'b0;
        check("mid mthi hi", HiE, 32'h0000_1234);
        run(40);
        check("mid mult hi",   HiE, 32'hFFFF_FFFF);
        check("mid mult lo",   LoE, 32'hFFFF_FFEB);
        check("mid mult done", 32'(done_n), 32'd1);

        // Asynchronous reset around iteration 10 of a DIV
        issue(3'd2, 32'd1000, 32'd3);
        run(10);
        check("pre-rst busy", {31'd0, BusyE}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("arst busy", {31'd0, BusyE}, 32'd0);
        check("arst hi",   HiE, 32'd0);
        check("arst lo",   LoE, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run(40);
        check("post-rst done", 32'(done_n), 32'd0);
        check("post-rst busy", 32'(busy_n), 32'd0);

        op_check("mult 6*7", 3'd0, 32'd6, 32'd7, 32'd0, 32'd42, 33, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
